line_buffer: RTL and testbench
==============================

Name: line_buffer

Overview:
Upstream feeder for the filter stage. Accepts a raster stream of single pixels and stores the previous HEIGHT_NB-1 image lines. Each accepted pixel emits one vertical column of HEIGHT_NB pixels: the new pixel plus the same-column pixels from the rows above it. The dn_img/dn_val pair connects directly to the filter's up_img/up_val inputs.

Parameters:
HEIGHT_NB, 3, number of rows per output column (must be >= 2)
IMG_WIDTH, 8, bits per pixel
LINE_LEN, 640, pixels per image line (must be >= 2)
COL_WIDTH, 10, column counter width; must satisfy 2**COL_WIDTH >= LINE_LEN

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
up_img  input  IMG_WIDTH  incoming pixel, raster order
up_val  input  1  up_img valid this cycle; no backpressure
up_eof  input  1  qualified by up_val; marks last pixel of frame
dn_img  output  HEIGHT_NB*IMG_WIDTH  column; slice h = pixel from row r-h, same column (slice 0 = newest)
dn_val  output  1  dn_img valid
dn_eof  output  1  up_eof delayed with dn_img
dn_col  output  COL_WIDTH  column index of dn_img

Behaviour:
- Clock is clk. Reset is synchronous and active-high on rst.
- Reset values: dn_img = 0, dn_val = 0, dn_eof = 0, dn_col = 0, col = 0, row = 0.
- Line storage is not cleared by reset. Stale contents are masked by the priming rule below.
- Storage: HEIGHT_NB-1 line arrays, each LINE_LEN x IMG_WIDTH, with asynchronous read (distributed RAM or registers).
  - Line k at address c holds the pixel from row r-1-k.
- On each cycle with up_val=1, at address col:
  - Read all lines first (read-before-write).
  - Write line 0 <= up_img.
  - Write line k <= old line k-1 (k >= 1).
  - Register the output: dn_img slice 0 = up_img; slice h = old line h-1 value, for h = 1..HEIGHT_NB-1.
- Latency: fixed at 1 cycle, up_val to dn_val.
- Throughput: one pixel per cycle; back-to-back and gapped up_val are both legal.
- Counters, updated on up_val:
  - col increments; at col = LINE_LEN-1 it wraps to 0 and row increments.
  - row saturates at HEIGHT_NB-1.
- Priming: dn_val <= up_val AND (row == HEIGHT_NB-1) at the time of the write.
  - The first HEIGHT_NB-1 lines of a frame produce no output.
- dn_col <= col and dn_eof <= up_eof & up_val, both registered in the same cycle as dn_img.
- End of frame: up_eof with up_val resets col and row to 0 after that pixel is processed. The pixel itself is output normally if primed.
  - Early eof (col != LINE_LEN-1) is still honoured: counters reset and the next frame re-primes.
- up_eof without up_val is ignored.
- When up_val=0: storage and counters hold; dn_val=0; dn_img holds its last value.
- rst asserted mid-frame: counters clear, dn_val=0 on the next cycle, and the next frame re-primes regardless of storage contents.

Test Plan:
- HEIGHT_NB=3, LINE_LEN=4; stream pixels 1..16 continuously, eof on 16 -> no dn_val for pixels 1..8. Pixel 9 gives dn_img={slice2=1, slice1=5, slice0=9}, dn_col=0, one cycle later. Pixel 16 gives {8,12,16} with dn_eof=1.
- Same stream with up_val toggled 1-0-1-0 -> identical output sequence; dn_val pulses only one cycle after each accepted pixel; dn_img holds during gaps.
- Two frames back-to-back, eof on pixel 16, frame 2 = 101..116 -> re-priming; first frame-2 output is at pixel 109 = {101,105,109}, with no frame-1 data leaking through.
- Early eof on pixel 6 (col 1 of row 1), then a new frame 201.. -> counters reset; first output at pixel 209 with dn_col=0; no dn_val during frame 1.
- rst asserted for one cycle after pixel 10 of a continuous stream -> dn_val=0 the following cycle; outputs resume only after two more full lines have been accepted.
- Wrap check with LINE_LEN=5, COL_WIDTH=3 -> dn_col sequence 0,1,2,3,4,0; no write ever goes to address 5..7.

Source files
------------

// File: rtl/line_buffer.sv
// Raster line buffer: stores the previous HEIGHT_NB-1 lines and emits one
// vertical column of HEIGHT_NB pixels per accepted input pixel, one cycle later.
module line_buffer #(
    parameter int HEIGHT_NB = 3,
    parameter int IMG_WIDTH = 8,
    parameter int LINE_LEN  = 640,
    parameter int COL_WIDTH = 10
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [IMG_WIDTH-1:0]           up_img,
    input  logic                           up_val,
    input  logic                           up_eof,
    output logic [HEIGHT_NB*IMG_WIDTH-1:0] dn_img,
    output logic                           dn_val,
    output logic                           dn_eof,
    output logic [COL_WIDTH-1:0]           dn_col
);

    localparam int ROW_W = $clog2(HEIGHT_NB);

    // Handshake: up_val qualifies up_img/up_eof for one cycle with no
    // backpressure; dn_val qualifies dn_img/dn_eof/dn_col for one cycle.
    logic [IMG_WIDTH-1:0] line_mem [HEIGHT_NB-1][LINE_LEN];
    logic [COL_WIDTH-1:0] col;
    logic [ROW_W-1:0]     row;
    logic                 last_col;
    logic                 primed;

    assign last_col = (col == COL_WIDTH'(LINE_LEN - 1));
    assign primed   = (row == ROW_W'(HEIGHT_NB - 1));

    // Storage is never reset; the priming row counter masks stale lines.
    always_ff @(posedge clk) begin
        if (up_val) begin
            line_mem[0][col] <= up_img;
            for (int k = 1; k < HEIGHT_NB - 1; k++) begin
                line_mem[k][col] <= line_mem[k-1][col];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dn_img <= '0;
            dn_val <= 1'b0;
            dn_eof <= 1'b0;
            dn_col <= '0;
            col    <= '0;
            row    <= '0;
        end else begin
            dn_val <= up_val && primed;
            dn_eof <= up_val && up_eof;
            if (up_val) begin
                dn_col                <= col;
                dn_img[IMG_WIDTH-1:0] <= up_img;
                for (int h = 1; h < HEIGHT_NB; h++) begin
                    dn_img[h*IMG_WIDTH +: IMG_WIDTH] <= line_mem[h-1][col];
                end
                // End of frame wins over line wrap so the next frame re-primes.
                if (up_eof) begin
                    col <= '0;
                    row <= '0;
                end else if (last_col) begin
                    col <= '0;
                    if (!primed) begin
                        row <= row + 1'b1;
                    end
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_line_buffer.sv
// Directed bench for line_buffer: a 3-row, 4-pixel-line instance for the
// main scenarios and a 5-pixel-line instance for the column wrap.
module tb_line_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic [7:0]  up_img = '0;
    logic        up_val = 1'b0;
    logic        up_eof = 1'b0;
    logic [23:0] dn_img;
    logic        dn_val;
    logic        dn_eof;
    logic [1:0]  dn_col;

    logic [7:0]  w_up_img = '0;
    logic        w_up_val = 1'b0;
    logic        w_up_eof = 1'b0;
    logic [23:0] w_dn_img;
    logic        w_dn_val;
    logic        w_dn_eof;
    logic [2:0]  w_dn_col;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    line_buffer #(.HEIGHT_NB(3), .IMG_WIDTH(8), .LINE_LEN(4), .COL_WIDTH(2)) u_dut (
        .clk(clk), .rst(rst),
        .up_img(up_img), .up_val(up_val), .up_eof(up_eof),
        .dn_img(dn_img), .dn_val(dn_val), .dn_eof(dn_eof), .dn_col(dn_col)
    );

    line_buffer #(.HEIGHT_NB(3), .IMG_WIDTH(8), .LINE_LEN(5), .COL_WIDTH(3)) u_wrap (
        .clk(clk), .rst(rst),
        .up_img(w_up_img), .up_val(w_up_val), .up_eof(w_up_eof),
        .dn_img(w_dn_img), .dn_val(w_dn_val), .dn_eof(w_dn_eof), .dn_col(w_dn_col)
    );

    // Drive one cycle of input, then leave outputs settled just after the edge.
    task automatic push(input bit val, input logic [7:0] img, input bit eof);
        @(negedge clk);
        up_val = val;
        up_img = img;
        up_eof = eof;
        @(posedge clk);
        #1;
    endtask

    task automatic push_w(input bit val, input logic [7:0] img, input bit eof);
        @(negedge clk);
        w_up_val = val;
        w_up_img = img;
        w_up_eof = eof;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        up_val = 1'b0;
        w_up_val = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (dn_val !== 1'b0) $display("FAIL reset dn_val got %0b want 0", dn_val);
        else n_pass++;
        n_checks++;
        if (dn_img !== 24'h0) $display("FAIL reset dn_img got %h want 000000", dn_img);
        else n_pass++;
        n_checks++;
        if (dn_eof !== 1'b0) $display("FAIL reset dn_eof got %0b want 0", dn_eof);
        else n_pass++;
        n_checks++;
        if (dn_col !== 2'd0) $display("FAIL reset dn_col got %0d want 0", dn_col);
        else n_pass++;
        n_checks++;
        if (w_dn_val !== 1'b0) $display("FAIL reset w_dn_val got %0b want 0", w_dn_val);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Streams n pixels base, base+1, ... starting at a fresh frame; eof on
    // index eof_at (-1 for none). Optional idle cycle after every pixel.
    task automatic stream_frame(input string tag, input int base, input int n,
                                input int eof_at, input bit gaps);
        logic [23:0] exp_img;
        bit          exp_val;
        for (int i = 0; i < n; i++) begin
            exp_val = (i >= 8);
            exp_img = {8'(base + i - 8), 8'(base + i - 4), 8'(base + i)};
            push(1'b1, 8'(base + i), i == eof_at);
            n_checks++;
            if (dn_val !== exp_val)
                $display("FAIL %s dn_val i=%0d got %0b want %0b", tag, i, dn_val, exp_val);
            else n_pass++;
            n_checks++;
            if (dn_eof !== (i == eof_at))
                $display("FAIL %s dn_eof i=%0d got %0b want %0b", tag, i, dn_eof, i == eof_at);
            else n_pass++;
            if (exp_val) begin
                n_checks++;
                if (dn_img !== exp_img)
                    $display("FAIL %s dn_img i=%0d got %h want %h", tag, i, dn_img, exp_img);
                else n_pass++;
                n_checks++;
                if (dn_col !== 2'(i % 4))
                    $display("FAIL %s dn_col i=%0d got %0d want %0d", tag, i, dn_col, i % 4);
                else n_pass++;
            end
            if (gaps) begin
                // eof without val must be ignored
                push(1'b0, 8'hEE, 1'b1);
                n_checks++;
                if (dn_val !== 1'b0 || dn_eof !== 1'b0)
                    $display("FAIL %s gap val/eof i=%0d got %0b/%0b want 0/0", tag, i, dn_val, dn_eof);
                else n_pass++;
                if (exp_val) begin
                    n_checks++;
                    if (dn_img !== exp_img)
                        $display("FAIL %s gap hold i=%0d got %h want %h", tag, i, dn_img, exp_img);
                    else n_pass++;
                end
            end
        end
        push(1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_continuous();
        stream_frame("cont", 1, 16, 15, 1'b0);
    endtask

    task automatic test_gapped();
        stream_frame("gap", 1, 16, 15, 1'b1);
    endtask

    task automatic test_back_to_back();
        stream_frame("f1", 1, 16, 15, 1'b0);
        stream_frame("f2", 101, 16, 15, 1'b0);
    endtask

    task automatic test_early_eof();
        stream_frame("early", 1, 6, 5, 1'b0);
        stream_frame("after_early", 201, 16, 15, 1'b0);
    endtask

    task automatic test_mid_reset();
        stream_frame("pre_rst", 1, 10, -1, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (dn_val !== 1'b0) $display("FAIL mid_rst dn_val got %0b want 0", dn_val);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        stream_frame("post_rst", 11, 12, 11, 1'b0);
    endtask

    task automatic test_wrap();
        logic [23:0] exp_img;
        for (int i = 0; i < 16; i++) begin
            exp_img = {8'(i + 1 - 10), 8'(i + 1 - 5), 8'(i + 1)};
            push_w(1'b1, 8'(i + 1), i == 15);
            n_checks++;
            if (w_dn_val !== (i >= 10))
                $display("FAIL wrap dn_val i=%0d got %0b want %0b", i, w_dn_val, i >= 10);
            else n_pass++;
            if (i >= 10) begin
                n_checks++;
                if (w_dn_col !== 3'(i % 5))
                    $display("FAIL wrap dn_col i=%0d got %0d want %0d", i, w_dn_col, i % 5);
                else n_pass++;
                n_checks++;
                if (w_dn_img !== exp_img)
                    $display("FAIL wrap dn_img i=%0d got %h want %h", i, w_dn_img, exp_img);
                else n_pass++;
            end
        end
        n_checks++;
        if (w_dn_eof !== 1'b1) $display("FAIL wrap dn_eof got %0b want 1", w_dn_eof);
        else n_pass++;
        push_w(1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        test_reset();
        test_continuous();
        test_gapped();
        test_back_to_back();
        test_early_eof();
        test_mid_reset();
        test_wrap();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
